// File: rtl/airlock_sequencer.sv
// ---------------------------------------------------------------------------
// airlock_sequencer
//
// Sequences the airlock chamber for arrivals (outside -> inside) and
// departures (inside -> outside). Owns the evacuation pump, the fill valve
// and both door unlocks, and arbitrates between simultaneous arrive/depart
// requests in round-robin order.
//
// Ports:
//   clk           system clock
//   rst           asynchronous active-high reset
//   arrive_req    synchronized arrival request level
//   depart_req    synchronized departure request level
//   inner_closed  inner door closed sensor (1 = closed)
//   outer_closed  outer door closed sensor (1 = closed)
//   fault_clr     clears the FAULT state when both doors are closed
//   evac_pump     chamber evacuation active
//   fill_valve    chamber pressurization active
//   inner_unlock  inner door may open
//   outer_unlock  outer door may open
//   busy          a sequence is in progress (state != IDLE)
//   dir           current/last served direction, 0 = arrive, 1 = depart
//   done          one-cycle pulse when a sequence completes
//   fault         door-interlock violation latched
//   pressurized   chamber pressure flag
// ---------------------------------------------------------------------------
module airlock_sequencer #(
    parameter int PRESS_CYCLES = 7,
    parameter int EVAC_CYCLES  = 7,
    parameter int CNT_W        = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic arrive_req,
    input  logic depart_req,
    input  logic inner_closed,
    input  logic outer_closed,
    input  logic fault_clr,
    output logic evac_pump,
    output logic fill_valve,
    output logic inner_unlock,
    output logic outer_unlock,
    output logic busy,
    output logic dir,
    output logic done,
    output logic fault,
    output logic pressurized
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] EVAC     = 3'd1;
    localparam logic [2:0] OPEN_OUT = 3'd2;
    localparam logic [2:0] PRESS    = 3'd3;
    localparam logic [2:0] OPEN_IN  = 3'd4;
    localparam logic [2:0] FINISH   = 3'd5;
    localparam logic [2:0] FAULT    = 3'd6;

    // Counter reload values: the step runs for LOAD+1 cycles because it
    // exits on the cycle the counter reads zero.
    localparam logic [CNT_W-1:0] EVAC_LOAD  = CNT_W'(EVAC_CYCLES - 1);
    localparam logic [CNT_W-1:0] PRESS_LOAD = CNT_W'(PRESS_CYCLES - 1);

    logic [2:0]       state;
    logic [2:0]       nextState;
    logic [CNT_W-1:0] counter;
    logic             phase;
    logic             dirReg;
    logic             pendArr;
    logic             pendDep;
    logic             pressReg;
    logic             doorSeenOpen;
    logic             servedOnce;

    logic             interlock;
    logic             serveDepart;
    logic             leaveIdle;
    logic [2:0]       vacStep;
    logic [2:0]       pressStep;

    // Arbitration, interlock detection and the chamber-step shortcuts.
    // A vacuum/pressure step is skipped entirely when the chamber is already
    // in the wanted condition. When both requests are pending the direction
    // opposite to the last served one wins, except that the very first grant
    // after reset goes to arrive (servedOnce distinguishes that case, since
    // dir itself resets to arrive).
    always_comb begin
        interlock   = 1'b0;
        serveDepart = 1'b0;
        leaveIdle   = 1'b0;
        vacStep     = pressReg ? EVAC : OPEN_OUT;
        pressStep   = pressReg ? OPEN_IN : PRESS;

        if ((state == EVAC || state == PRESS) && !(inner_closed && outer_closed))
            interlock = 1'b1;
        if (state == OPEN_OUT && !inner_closed)
            interlock = 1'b1;
        if (state == OPEN_IN && !outer_closed)
            interlock = 1'b1;

        if (pendArr && pendDep)
            serveDepart = servedOnce ? ~dirReg : 1'b0;
        else
            serveDepart = pendDep;

        leaveIdle = (state == IDLE) && (pendArr || pendDep);
    end

    // Next-state selection. The phase bit tells an OPEN state whether it is
    // the first door of the sequence (continue to the other chamber step) or
    // the second (finish). An interlock violation overrides everything.
    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (leaveIdle)
                    nextState = serveDepart ? pressStep : vacStep;
            end
            EVAC: begin
                if (counter == '0)
                    nextState = OPEN_OUT;
            end
            PRESS: begin
                if (counter == '0)
                    nextState = OPEN_IN;
            end
            OPEN_OUT: begin
                if (outer_closed && doorSeenOpen)
                    nextState = phase ? FINISH : pressStep;
            end
            OPEN_IN: begin
                if (inner_closed && doorSeenOpen)
                    nextState = phase ? FINISH : vacStep;
            end
            FINISH: begin
                nextState = IDLE;
            end
            FAULT: begin
                if (fault_clr && inner_closed && outer_closed)
                    nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
        if (interlock)
            nextState = FAULT;
    end

    // Sequential state. Entry actions (counter load, door-seen clear) fire on
    // the edge that changes state; the pressure flag only changes when a pump
    // or fill step completes normally, so a fault mid-step leaves it alone.
    // A request seen on the same edge that starts its own sequence is
    // absorbed by that sequence.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            counter      <= '0;
            phase        <= 1'b0;
            dirReg       <= 1'b0;
            pendArr      <= 1'b0;
            pendDep      <= 1'b0;
            pressReg     <= 1'b1;
            doorSeenOpen <= 1'b0;
            servedOnce   <= 1'b0;
        end else begin
            state <= nextState;

            pendArr <= (leaveIdle && !serveDepart) ? 1'b0 : (pendArr | arrive_req);
            pendDep <= (leaveIdle && serveDepart) ? 1'b0 : (pendDep | depart_req);

            if (leaveIdle) begin
                dirReg     <= serveDepart;
                phase      <= 1'b0;
                servedOnce <= 1'b1;
            end

            if ((state == OPEN_OUT || state == OPEN_IN) && nextState != state
                && nextState != FAULT)
                phase <= 1'b1;

            if (state == EVAC && nextState == OPEN_OUT)
                pressReg <= 1'b0;
            if (state == PRESS && nextState == OPEN_IN)
                pressReg <= 1'b1;

            if (nextState != state) begin
                if (nextState == EVAC)
                    counter <= EVAC_LOAD;
                else if (nextState == PRESS)
                    counter <= PRESS_LOAD;
                if (nextState == OPEN_OUT || nextState == OPEN_IN)
                    doorSeenOpen <= 1'b0;
            end else begin
                if (state == EVAC || state == PRESS)
                    counter <= counter - 1'b1;
                if (state == OPEN_OUT && !outer_closed)
                    doorSeenOpen <= 1'b1;
                if (state == OPEN_IN && !inner_closed)
                    doorSeenOpen <= 1'b1;
            end
        end
    end

    assign evac_pump    = (state == EVAC);
    assign fill_valve   = (state == PRESS);
    assign inner_unlock = (state == OPEN_IN);
    assign outer_unlock = (state == OPEN_OUT);
    assign busy         = (state != IDLE);
    assign done         = (state == FINISH);
    assign fault        = (state == FAULT);
    assign dir          = dirReg;
    assign pressurized  = pressReg;

endmodule

// File: doc/airlock_sequencer.md
Name: airlock_sequencer

Overview:
- Sequences the airlock chamber for arrivals (outside to inside) and departures (inside to outside).
- Drives the evacuation pump, fill valve and the inner/outer door unlocks.
- Arbitrates between simultaneous arrive/depart requests.
- Takes metastability-filtered request and door-sensor levels from the arrive/depart signal front end and owns all chamber actuators.

Parameters:
PRESS_CYCLES, 7, clock cycles fill_valve is held high for one pressurize (>=1)
EVAC_CYCLES, 7, clock cycles evac_pump is held high for one evacuate (>=1)
CNT_W, 10, width of internal duration counter; both cycle parameters must be < 2^CNT_W

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
arrive_req  input  1  synchronized arrival request level
depart_req  input  1  synchronized departure request level
inner_closed  input  1  inner door closed sensor, 1 = closed
outer_closed  input  1  outer door closed sensor, 1 = closed
fault_clr  input  1  clears FAULT state
evac_pump  output  1  chamber evacuation active
fill_valve  output  1  chamber pressurization active
inner_unlock  output  1  inner door may open
outer_unlock  output  1  outer door may open
busy  output  1  a sequence is in progress (state != IDLE)
dir  output  1  current/last served direction, 0 = arrive, 1 = depart
done  output  1  one-cycle pulse when a sequence completes
fault  output  1  door-interlock violation latched
pressurized  output  1  chamber pressure flag

Behaviour:
- Reset (async, rst=1): state=IDLE, pending_arr=pending_dep=0, pressurized=1, dir=0, counter=0, door_seen_open=0, all outputs 0 except pressurized=1.
- All outputs are decoded from registered state only; there is no combinational input-to-output path.
- Pending latches: any edge with arrive_req=1 sets pending_arr, and likewise for depart_req. Set requests persist until the sequence serving them starts. A request asserted while busy is queued.
- States: IDLE, EVAC, OPEN_OUT, PRESS, OPEN_IN, FINISH, FAULT.
- IDLE:
  - If exactly one pending bit is set, serve it.
  - If both are set, serve the direction opposite to dir (round-robin); after reset, arrive wins.
  - On the leaving edge: set dir, clear the served pending bit, set phase=0.
  - Arrive path: first step is chamber-to-vacuum, then OPEN_OUT.
  - Depart path: first step is chamber-to-pressure, then OPEN_IN.
- Chamber-to-vacuum:
  - If pressurized=0, go directly to OPEN_OUT with 0 pump cycles.
  - Otherwise enter EVAC with counter=EVAC_CYCLES-1. evac_pump=1 in every EVAC cycle.
  - When counter==0: clear pressurized and advance. evac_pump is therefore high for exactly EVAC_CYCLES cycles.
- Chamber-to-pressure: same as chamber-to-vacuum, using PRESS, fill_valve, PRESS_CYCLES, and setting pressurized=1.
- OPEN_OUT / OPEN_IN:
  - The matching unlock is 1; door_seen_open is cleared on entry.
  - The state exits on the first edge where closed=1 and door_seen_open=1, i.e. the door has opened then re-closed. There is no timeout.
- Arrive order: EVAC, OPEN_OUT, PRESS, OPEN_IN, FINISH.
- Depart order: PRESS, OPEN_IN, EVAC, OPEN_OUT, FINISH.
- The phase bit selects the next step.
- FINISH: done=1 for exactly one cycle, then IDLE. busy=0 only in IDLE.
- Interlock violation:
  - Condition: in EVAC or PRESS with either door not closed, or in OPEN_OUT with inner_closed=0, or in OPEN_IN with outer_closed=0.
  - Response: go to FAULT on the next edge. FAULT has all actuators 0 and fault=1; pending bits are retained.
  - pressurized is left unchanged if the violation occurs mid-EVAC/PRESS.
  - FAULT exits to IDLE on an edge with fault_clr=1 and both doors closed; fault_clr is ignored otherwise.
- Invariants:
  - inner_unlock and outer_unlock are never both 1.
  - evac_pump and fill_valve are never both 1.
  - Neither pump nor valve is on while either unlock is on.
- Counter: CNT_W bits, down-count, loaded on entry to EVAC/PRESS. It never underflows because the state exits at 0.
- Reset mid-sequence: immediate return to reset values. The sequence is abandoned and pending requests are lost.

Test Plan:
- Arrive, PRESS_CYCLES=4, EVAC_CYCLES=3, chamber pressurized, doors closed, arrive_req pulse 1 cycle:
  - evac_pump high 3 cycles, then outer_unlock until outer_closed toggles 1->0->1.
  - Then fill_valve high 4 cycles, then inner_unlock until inner door cycles.
  - Then done pulse 1 cycle, pressurized=1, busy=0.
- Depart with chamber already pressurized: PRESS step is skipped (fill_valve never high), inner_unlock 1 cycle after leaving IDLE; sequence ends with pressurized=0, done=1.
- arrive_req and depart_req asserted the same cycle after reset: arrive served first (dir=0), depart served immediately after FINISH (dir=1); two done pulses total.
- outer_closed dropped to 0 during EVAC cycle 2: next cycle fault=1, all actuators 0. fault_clr while outer open stays FAULT; fault_clr with both closed returns to IDLE next edge.
- rst asserted mid-PRESS with fill_valve=1: outputs drop asynchronously to reset values (pressurized=1, busy=0), no done pulse.
- Request arriving during busy: depart_req pulsed during arrive OPEN_OUT is latched and starts on the edge after FINISH returns to IDLE.
